// File: rtl/cirno_pkg.sv
// cirno_pkg: shared types, constants and the instruction decode function for
// the Cirno decode stage.
// Optional feature: CIRNO_DECODE_ILLEGAL_EN makes reserved 0_0000_00_1x decode
// as an illegal-instruction bundle instead of a nop.
package cirno_pkg;

    localparam logic [2:0] T_ALU   = 3'd1;
    localparam logic [2:0] T_NOBR  = 3'd2;
    localparam logic [2:0] T_BRREG = 3'd3;
    localparam logic [2:0] T_MOV   = 3'd4;
    localparam logic [2:0] T_ST    = 3'd5;
    localparam logic [2:0] T_LD    = 3'd6;

    localparam logic [3:0] F_AND = 4'b0011;
    localparam logic [3:0] F_INC = 4'b0101;
    localparam logic [3:0] F_CMP = 4'b0110;
    localparam logic [3:0] F_SHR = 4'b0111;
    localparam logic [3:0] F_SHL = 4'b1110;

    // Immediates never exceed 6 bits; the stage zero-extends to IMM_W.
    typedef struct packed {
        logic [1:0] r1;
        logic [1:0] r2;
        logic [2:0] inst_type;
        logic [3:0] funct;
        logic [5:0] imm;
        logic       branch;
        logic       branchi;
        logic       jump;
        logic       reg_hi_en;
        logic       reg_lo_en;
        logic       reg_readx_en;
        logic       reg_ready_en;
        logic       reg_swap_en;
        logic       is_cmp;
        logic       y_is_imm;
        logic       done;
        logic       illegal;
    } decode_bundle_t;

    function automatic decode_bundle_t decode(input logic [8:0] inst, input logic cmp);
        decode_bundle_t b;
        b = '0;
        if (inst[8]) begin
            b.r1  = inst[5:4];
            b.imm = {2'b00, inst[3:0]};
            if (inst[7:6] == 2'b11) begin
                b.r1        = 2'b00;
                b.inst_type = T_NOBR;
                b.branchi   = 1'b1;
                b.jump      = 1'b1;
                b.imm       = inst[5:0];
            end else if (inst[7:6] == 2'b10) begin
                b.inst_type    = T_ALU;
                b.reg_readx_en = 1'b1;
                b.y_is_imm     = 1'b1;
                b.funct        = F_AND;
            end else begin
                b.inst_type = T_MOV;
                b.reg_hi_en = inst[6];
                b.reg_lo_en = ~inst[6];
            end
        end else if (inst[7:6] == 2'b11) begin
            b.inst_type    = T_ALU;
            b.r1           = inst[4:3];
            b.imm          = {3'b000, inst[2:0]};
            b.reg_readx_en = 1'b1;
            b.y_is_imm     = 1'b1;
            b.funct        = inst[5] ? F_SHR : F_SHL;
        end else if (inst[7:4] == 4'b1011) begin
            b.inst_type = T_NOBR;
            b.branchi   = cmp;
            b.imm       = cmp ? {2'b00, inst[3:0]} : 6'd0;
        end else if (inst[7:4] == 4'b0000) begin
            b.r1           = inst[1:0];
            b.reg_readx_en = 1'b1;
            b.inst_type    = T_NOBR;
            case (inst[3:2])
                2'b11: begin
                    b.inst_type = T_ALU;
                    b.funct     = F_INC;
                    b.imm       = 6'd1;
                    b.y_is_imm  = 1'b1;
                end
                2'b10: begin
                    b.inst_type = T_BRREG;
                    b.branch    = 1'b1;
                end
                2'b01: begin
                    b.inst_type = cmp ? T_BRREG : T_NOBR;
                    b.branch    = cmp;
                end
                default: begin
                    b.done = (inst[1:0] == 2'b01);
`ifdef CIRNO_DECODE_ILLEGAL_EN
                    if (inst[1]) begin
                        b              = '0;
                        b.inst_type    = T_NOBR;
                        b.illegal      = 1'b1;
                    end
`endif
                end
            endcase
        end else begin
            b.r1           = inst[3:2];
            b.r2           = inst[1:0];
            b.reg_readx_en = 1'b1;
            b.reg_ready_en = 1'b1;
            case (inst[7:4])
                4'b1001: b.inst_type = T_ST;
                4'b1000: b.inst_type = T_LD;
                4'b0111: begin
                    b.inst_type   = T_MOV;
                    b.reg_swap_en = 1'b1;
                end
                default: begin
                    b.inst_type = T_ALU;
                    b.funct     = inst[7:4];
                    b.is_cmp    = (inst[7:4] == F_CMP);
                end
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/cirno_decode_fifo.sv
// cirno_decode_fifo: DEPTH-entry FIFO of decoded bundles.
// Ports: clk, rst_n (async active-low), clr (sync flush, highest priority),
// push/din, pop/dout (head), full, empty.
module cirno_decode_fifo
    import cirno_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           push,
    input  logic           pop,
    input  decode_bundle_t din,
    output decode_bundle_t dout,
    output logic           full,
    output logic           empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]    wr_ptr, rd_ptr;
    decode_bundle_t mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !clr)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cirno_decode_stage.sv
// cirno_decode_stage: pipelined Cirno decoder with a DEPTH-entry output FIFO
// and sticky halt tracking.
// Ports: clk, rst_n (async active-low), init (sync restart); in_valid/in_ready/
// inst/cmp from fetch; out_valid/out_ready plus the decoded bundle fields
// (r1, r2, inst_type, funct, immediate, control enables, done, illegal) to
// execute; halted status.
// Optional feature macro: CIRNO_DECODE_ILLEGAL_EN (see cirno_pkg).
module cirno_decode_stage
    import cirno_pkg::*;
#(
    parameter int IMM_W = 6,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       inst,
    input  logic             cmp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       r1,
    output logic [1:0]       r2,
    output logic [2:0]       inst_type,
    output logic [3:0]       funct,
    output logic [IMM_W-1:0] immediate,
    output logic             branch,
    output logic             branchi,
    output logic             jump,
    output logic             reg_hi_en,
    output logic             reg_lo_en,
    output logic             reg_readx_en,
    output logic             reg_ready_en,
    output logic             reg_swap_en,
    output logic             is_cmp,
    output logic             y_is_imm,
    output logic             done,
    output logic             illegal,
    output logic             halted
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t         state_q, state_d;
    logic           live;
    logic           full, empty, accept;
    decode_bundle_t dec, head, raw;

    // live holds in_ready low while reset is asserted so every output reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            live    <= 1'b0;
        end else begin
            state_q <= state_d;
            live    <= 1'b1;
        end
    end

    assign dec    = decode(inst, cmp);
    assign accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        if (init)
            state_d = RUN;
        else if (accept && (dec.done || dec.illegal))
            state_d = HALTED;
    end

    assign in_ready  = live && (state_q == RUN) && !full;
    assign halted    = (state_q == HALTED);
    assign out_valid = !empty;

    cirno_decode_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (init),
        .push  (accept),
        .pop   (out_ready && !empty),
        .din   (dec),
        .dout  (raw),
        .full  (full),
        .empty (empty)
    );

    assign head = empty ? '0 : raw;

    assign r1           = head.r1;
    assign r2           = head.r2;
    assign inst_type    = head.inst_type;
    assign funct        = head.funct;
    assign immediate    = IMM_W'(head.imm);
    assign branch       = head.branch;
    assign branchi      = head.branchi;
    assign jump         = head.jump;
    assign reg_hi_en    = head.reg_hi_en;
    assign reg_lo_en    = head.reg_lo_en;
    assign reg_readx_en = head.reg_readx_en;
    assign reg_ready_en = head.reg_ready_en;
    assign reg_swap_en  = head.reg_swap_en;
    assign is_cmp       = head.is_cmp;
    assign y_is_imm     = head.y_is_imm;
    assign done         = head.done;
    assign illegal      = head.illegal;

endmodule

// File: tb/tb_cirno_decode_stage.sv
// tb_cirno_decode_stage: scoreboard-based self-checking bench for cirno_decode_stage.
module tb_cirno_decode_stage;

    // Expected bundle: {r1, r2, type, funct, imm[7:0], 12 control flags}.
    typedef logic [30:0] exp_t;
    localparam logic [11:0] BR = 12'h800, BRI = 12'h400, JMP = 12'h200, HI = 12'h100,
                            LO = 12'h080, RX = 12'h040, RY = 12'h020, SW = 12'h010,
                            IC = 12'h008, YI = 12'h004, DN = 12'h002, IL = 12'h001;

    logic       clk = 0, rst_n = 0, init = 0, in_valid = 0, cmp = 0, out_ready = 0;
    logic [8:0] inst = '0;
    logic       in_ready, out_valid;
    logic [1:0] r1, r2;
    logic [2:0] inst_type;
    logic [3:0] funct;
    logic [7:0] immediate;
    logic       branch, branchi, jump, reg_hi_en, reg_lo_en, reg_readx_en, reg_ready_en;
    logic       reg_swap_en, is_cmp, y_is_imm, done, illegal, halted;

    int   checks = 0, failures = 0;
    exp_t sb[$];

    cirno_decode_stage #(.IMM_W(8), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .cmp(cmp), .out_valid(out_valid), .out_ready(out_ready),
        .r1(r1), .r2(r2), .inst_type(inst_type), .funct(funct), .immediate(immediate),
        .branch(branch), .branchi(branchi), .jump(jump), .reg_hi_en(reg_hi_en),
        .reg_lo_en(reg_lo_en), .reg_readx_en(reg_readx_en), .reg_ready_en(reg_ready_en),
        .reg_swap_en(reg_swap_en), .is_cmp(is_cmp), .y_is_imm(y_is_imm), .done(done),
        .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] a, input logic [1:0] b, input logic [2:0] t,
                                input logic [3:0] f, input logic [7:0] im, input logic [11:0] fl);
        return {a, b, t, f, im, fl};
    endfunction

    function automatic exp_t obs();
        return {r1, r2, inst_type, funct, immediate, branch, branchi, jump, reg_hi_en,
                reg_lo_en, reg_readx_en, reg_ready_en, reg_swap_en, is_cmp, y_is_imm, done, illegal};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    // Present one instruction, waiting (bounded) for in_ready; push its expectation.
    task automatic send(input string nm, input logic [8:0] i, input logic c, input exp_t e);
        int n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL %s in_ready timeout got=%b exp=1", nm, in_ready);
        end else begin
            inst = i; cmp = c; in_valid = 1;
            sb.push_back(e);
            step();
            in_valid = 0;
        end
    endtask

    // Wait (bounded) for a head bundle, compare it with the scoreboard, pop it.
    task automatic check_head(input string nm);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 20) begin step(); n++; end
        checks++;
        if (!out_valid || sb.size() == 0) begin
            failures++;
            $display("FAIL %s no output got_valid=%b exp_entries=%0d", nm, out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if (obs() !== e) begin
                failures++;
                $display("FAIL %s bundle got=%h exp=%h", nm, obs(), e);
            end
            out_ready = 1;
            step();
            out_ready = 0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (obs() !== '0 || out_valid !== 0 || in_ready !== 0 || halted !== 0) begin
            failures++;
            $display("FAIL reset outputs got=%h v=%b r=%b h=%b exp=0", obs(), out_valid, in_ready, halted);
        end
        rst_n = 1;
        step();
        chk("reset in_ready", in_ready, 1'b1);
    endtask

    task automatic test_jmpi();
        send("jmpi", 9'b1_11_000101, 0, mk(0, 0, 2, 0, 5, BRI | JMP));
        chk("jmpi latency", out_valid, 1'b1);
        check_head("jmpi");
    endtask

    task automatic test_beqi();
        send("beqi0", 9'b0_1011_0011, 0, mk(0, 0, 2, 0, 0, 0));
        send("beqi1", 9'b0_1011_0011, 1, mk(0, 0, 2, 0, 3, BRI));
        check_head("beqi0");
        check_head("beqi1");
    endtask

    task automatic test_decode();
        send("movhi", 9'b1_01_10_1010, 0, mk(2, 0, 4, 0, 10, HI));          check_head("movhi");
        send("movli", 9'b1_00_01_0111, 0, mk(1, 0, 4, 0, 7, LO));           check_head("movli");
        send("andi",  9'b1_10_11_0110, 0, mk(3, 0, 1, 3, 6, RX | YI));      check_head("andi");
        send("shri",  9'b0_11_1_01_101, 0, mk(1, 0, 1, 7, 5, RX | YI));     check_head("shri");
        send("shli",  9'b0_11_0_10_011, 0, mk(2, 0, 1, 14, 3, RX | YI));    check_head("shli");
        send("incr",  9'b0_0000_11_10, 0, mk(2, 0, 1, 5, 1, RX | YI));      check_head("incr");
        send("jmp",   9'b0_0000_10_01, 0, mk(1, 0, 3, 0, 0, RX | BR));      check_head("jmp");
        send("beq1",  9'b0_0000_01_11, 1, mk(3, 0, 3, 0, 0, RX | BR));      check_head("beq1");
        send("beq0",  9'b0_0000_01_11, 0, mk(3, 0, 2, 0, 0, RX));           check_head("beq0");
        send("nop",   9'b0_0000_00_00, 1, mk(0, 0, 2, 0, 0, RX));           check_head("nop");
        send("cmp",   9'b0_0110_01_10, 0, mk(1, 2, 1, 6, 0, RX | RY | IC)); check_head("cmp");
        send("store", 9'b0_1001_11_00, 0, mk(3, 0, 5, 0, 0, RX | RY));      check_head("store");
        send("load",  9'b0_1000_10_11, 0, mk(2, 3, 6, 0, 0, RX | RY));      check_head("load");
        send("mv",    9'b0_0111_00_01, 0, mk(0, 1, 4, 0, 0, RX | RY | SW)); check_head("mv");
        send("add",   9'b0_0001_10_01, 0, mk(2, 1, 1, 1, 0, RX | RY));      check_head("add");
    endtask

    task automatic test_full();
        exp_t e;
        send("fullA", 9'b0_0010_00_01, 0, mk(0, 1, 1, 2, 0, RX | RY));
        send("fullB", 9'b0_0011_01_10, 0, mk(1, 2, 1, 3, 0, RX | RY));
        chk("full in_ready", in_ready, 1'b0);
        inst = 9'b0_0100_11_11; in_valid = 1; out_ready = 1;
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL fullA head got=%h exp=%h", obs(), e); end
        sb.push_back(mk(3, 3, 1, 4, 0, RX | RY));
        step();
        chk("full ready after pop", in_ready, 1'b1);
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL fullB head got=%h exp=%h", obs(), e); end
        step();
        in_valid = 0; out_ready = 0;
        check_head("fullC");
        chk("full drained", out_valid, 1'b0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                e = sb.pop_front();
                checks++;
                if (out_valid !== 1 || obs() !== e) begin
                    failures++;
                    $display("FAIL b2b[%0d] got=%h v=%b exp=%h", i, obs(), out_valid, e);
                end
            end
            chk("b2b in_ready", in_ready, 1'b1);
            inst = {7'b0_0000_11, 2'(i)}; in_valid = 1;
            sb.push_back(mk(2'(i), 0, 1, 5, 1, RX | YI));
            step();
        end
        in_valid = 0;
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL b2b last got=%h exp=%h", obs(), e); end
        step();
        out_ready = 0;
        chk("b2b empty", out_valid, 1'b0);
    endtask

    task automatic test_halt();
        send("halt", 9'b0_0000_00_01, 0, mk(1, 0, 2, 0, 0, RX | DN));
        chk("halt halted", halted, 1'b1);
        chk("halt in_ready", in_ready, 1'b0);
        inst = 9'b0_0001_00_00; in_valid = 1;
        step(); step();
        chk("halt blocks accept", in_ready, 1'b0);
        in_valid = 0;
        check_head("halt bundle");
        chk("halt no extra", out_valid, 1'b0);
        chk("halt sticky", halted, 1'b1);
        init = 1;
        step();
        init = 0;
        chk("init halted", halted, 1'b0);
        chk("init in_ready", in_ready, 1'b1);
    endtask

    task automatic test_init_flush();
        send("flushA", 9'b0_0001_00_00, 0, '0);
        send("flushB", 9'b0_0001_00_00, 0, '0);
        init = 1;
        step();
        init = 0;
        sb.delete();
        chk("init flush empty", out_valid, 1'b0);
        chk("init flush ready", in_ready, 1'b1);
    endtask

    task automatic test_reserved();
`ifdef CIRNO_DECODE_ILLEGAL_EN
        send("illegal", 9'b0_0000_00_10, 0, mk(0, 0, 2, 0, 0, IL));
        chk("illegal halted", halted, 1'b1);
        check_head("illegal");
        init = 1;
        step();
        init = 0;
`else
        send("reserved", 9'b0_0000_00_10, 0, mk(2, 0, 2, 0, 0, RX));
        chk("reserved halted", halted, 1'b0);
        chk("reserved in_ready", in_ready, 1'b1);
        check_head("reserved");
`endif
    endtask

    task automatic test_async_reset();
        send("arA", 9'b0_0001_00_00, 0, '0);
        send("arB", 9'b0_0000_00_01, 0, '0);
        #2 rst_n = 0;
        #1;
        sb.delete();
        chk("async out_valid", out_valid, 1'b0);
        chk("async halted", halted, 1'b0);
        #1 rst_n = 1;
        step();
        send("post reset", 9'b1_11_111111, 0, mk(0, 0, 2, 0, 63, BRI | JMP));
        check_head("post reset");
    endtask

    initial begin
        test_reset();
        test_jmpi();
        test_beqi();
        test_decode();
        test_full();
        test_back_to_back();
        test_halt();
        test_init_flush();
        test_reserved();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cirno_decode_stage.md
# cirno_decode_stage

Parametrised, pipelined successor to the Cirno single-cycle instruction decoder. Accepts 9-bit instructions over a valid/ready handshake and decodes them into the control bundle used by the register file, ALU and branch unit. Queues decoded bundles in a DEPTH-entry output FIFO and tracks halt state. Sits between fetch and the execute/register stage and decouples their stalls.

## Interface
- IMM_W, 6: immediate width; decoded immediates are zero-extended to IMM_W (must be ≥6).
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- init  in  1  synchronous restart: flush FIFO, clear halt.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept.
- inst  in  9  instruction word.
- cmp  in  1  compare flag, sampled on accept.
- out_valid  out  1  head bundle valid.
- out_ready  in  1  consumer takes head.
- r1, r2  out  2 each  register selects.
- inst_type  out  3  instruction class.
- funct  out  4  ALU function.
- immediate  out  IMM_W  immediate.
- branch, branchi, jump, reg_hi_en, reg_lo_en, reg_readx_en, reg_ready_en, reg_swap_en, is_cmp, y_is_imm, done, illegal  out  1 each  decoded controls.
- halted  out  1  sticky halt status.

## Operation
- Decode table, bit 8 down to 0; every field not listed is 0 in the bundle:
  - 1_11_iiiiii jmpi: type 2, branchi, jump, imm=[5:0].
  - 1_01_rr_iiii movhi, type 4, reg_hi_en. 1_00_rr_iiii movli, type 4, reg_lo_en. Both: r1=[5:4], imm=[3:0].
  - 1_10_rr_iiii andi: type 1, r1=[5:4], readx, y_is_imm, funct 0011, imm=[3:0].
  - 0_11_s_rr_iii shift: type 1, r1=[4:3], imm=[2:0], readx, y_is_imm; funct 0111 if s (shri), else 1110 (shli).
  - 0_1011_iiii beqi: type 2; if cmp, branchi and imm=[3:0].
  - 0_0000_oo_rr: r1=[1:0], readx. oo=11 incr: type 1, funct 0101, imm 1, y_is_imm. oo=10 jmp: type 3, branch. oo=01 beq: cmp ? type 3 + branch : type 2. oo=00: type 2; rr=01 halt (done=1); rr=00 nop; rr=1x reserved.
  - Otherwise: r1=[3:2], r2=[1:0], readx, ready; op=[7:4]: 1001 store type 5; 1000 load type 6; 0111 mv type 4 + swap; 0110 cmp type 1, is_cmp, funct=op; other ops type 1, funct=op.
- FSM states: RUN and HALTED. in_ready = RUN && FIFO not full.
- Accept (in_valid && in_ready): decode inst with the current cmp; push the bundle.
- Accepting halt pushes a bundle with done=1 and moves to HALTED. HALTED holds until init; the FIFO keeps draining.
- Pop on out_valid && out_ready. Outputs show the FIFO head; all outputs are 0 while empty.
- init has priority over accept and pop: FIFO emptied, state RUN, halted=0.

## Timing
- Reset: FIFO empty, state RUN, every output 0 (in_ready 1 after release).
- Latency: an instruction accepted at edge N is visible with out_valid at N+1. No combinational path from inst to outputs.
- Full: in_ready=0; no bypass even if out_ready=1 in the same cycle. in_ready rises the cycle after a pop.
- Push and pop in the same cycle when not full or empty: occupancy unchanged. Pointers wrap modulo DEPTH.
- Halt accepted at edge N: in_ready=0 from N; halted=1 from N.
- Reset asserted mid-operation clears state immediately, asynchronously.

## Configuration
- CIRNO_DECODE_ILLEGAL_EN defined: reserved 0_0000_00_1x produces a bundle with illegal=1, type 2, all enables 0. The stage then enters HALTED exactly as for halt, with done=0.
- Not defined: the illegal port is tied to 0, and reserved encodings decode as nop.

## Structure
- cirno_pkg: inst_type constants (ALU=1, NOBR=2, BRREG=3, MOV=4, ST=5, LD=6), funct constants, decode_bundle_t packed struct, and the decode function.
- Sub-module cirno_decode_fifo: parameterised by DEPTH, stores decode_bundle_t, provides full/empty.

## Test plan
- Reset, then send 1_11_000101 → next cycle out_valid=1, jump=1, branchi=1, imm=5, type=2.
- beqi 0_1011_0011 with cmp=0, then with cmp=1 → first branchi=0, imm=0; second branchi=1, imm=3.
- out_ready=0, stream 3 instructions with DEPTH=2 → in_ready=0 after 2 accepts; set out_ready=1 → entries emerge in order, third accepted.
- halt 0_0000_00_01 followed by valid add → done=1 bundle, halted=1, in_ready stays 0; init → FIFO empty, in_ready=1.
- 0_0110_01_10 (cmp r1=1, r2=2) → is_cmp=1, funct=0110, readx=1, ready=1.
- With the macro: 0_0000_00_10 → illegal=1, halted=1. Without the macro: decodes as nop, in_ready stays 1.
